sr_debug_ctrl: RTL
==================

// Module: sr_debug_ctrl
// PURPOSE
//  Run-control sequencer for the single-cycle schoolRISCV core: gates CPU advance via cpuEn
//  (RUN / HALT / STEP n), stops on one PC breakpoint and counts retired instructions.
//  Owns the core's debug register port: DUMP streams addr 0 (PC) and x1..x31 over valid/ready.
//  Sits between the host command interface and the core; the core's PC and regfile write update
//  only on clk edges where cpuEn=1.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter instrCnt (wraps modulo 2^CNT_W)
//  STEP_W  16  width of STEP count taken from cmdArg[STEP_W-1:0]
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  cmdValid   in   1      host command valid
//  cmdReady   out  1      command accepted on edge where cmdValid&&cmdReady
//  cmdOp      in   3      0 NOP,1 RUN,2 HALT,3 STEP,4 SET_BP,5 CLR_BP,6 DUMP,7 CLR_CNT
//  cmdArg     in   32     STEP count (low STEP_W bits) / SET_BP byte address
//  cpuPc      in   32     core's current PC (byte address)
//  cpuEn      out  1      core advances one instruction at this edge
//  dbgRegAddr out  5      to core debug port address (0 returns PC)
//  dbgRegData in   32     from core debug port, combinational
//  dumpValid  out  1      dump beat valid
//  dumpReady  in   1      dump sink ready
//  dumpAddr   out  5      register index of current beat
//  dumpData   out  32     = dbgRegData
//  state      out  2      0 HALT,1 RUN,2 STEP,3 DUMP
//  bpHit      out  1      sticky: last stop caused by breakpoint
//  instrCnt   out  CNT_W  count of cycles with cpuEn=1
// BEHAVIOUR
//  Reset: state=HALT, cpuEn=0, bpEn=0, bpAddr=0, bpHit=0, instrCnt=0, stepCnt=0, dumpAddr=0,
//   dumpValid=0, skipBp=0. Reset mid-DUMP/STEP/RUN aborts immediately, no partial state kept.
//  Commands take effect at the accepting edge; new state visible next cycle.
//  cmdReady=1 in HALT, RUN, STEP; 0 in DUMP.
//  HALT state: all ops act. RUN->RUN (skipBp=1, bpHit=0); STEP->STEP (stepCnt=max(arg,1), bpHit=0);
//   DUMP->DUMP (dumpAddr=0); HALT/NOP no-op.
//  RUN/STEP state: HALT->HALT; SET_BP/CLR_BP/CLR_CNT act; RUN, STEP, DUMP, NOP consumed, no effect.
//  SET_BP: bpAddr=cmdArg, bpEn=1. CLR_BP: bpEn=0. Both legal in any accepting state.
//  cpuEn (combinational): RUN: 1 unless (bpEn && cpuPc==bpAddr && !skipBp); STEP: 1; else 0.
//  RUN: breakpoint match (non-skipped) -> cpuEn=0 that cycle, next state HALT, bpHit=1.
//   skipBp clears after first cycle in RUN, so resuming at bpAddr executes it once.
//  STEP: breakpoints ignored; stepCnt decrements each cycle; cycle with stepCnt==1 -> HALT next.
//  HALT accepted in RUN/STEP: instruction in the accepting cycle still executes (cpuEn per rule).
//  instrCnt += 1 on every edge with cpuEn=1; wraps; CLR_CNT zeroes it and wins over same-edge increment.
//  DUMP: dumpValid=1, dbgRegAddr=dumpAddr; beat on dumpValid&&dumpReady -> dumpAddr++;
//   beat at dumpAddr=31 -> HALT, dumpAddr=0. Addr/data held while dumpReady=0. cpuEn=0 throughout.
//  Outside DUMP, dbgRegAddr=0 (core PC observable).
// TESTING
//  rst, STEP arg=5 over nop program -> exactly 5 cpuEn cycles, instrCnt=5, state=HALT, cpuPc=0x14.
//  STEP arg=0 -> exactly 1 cpuEn cycle; instrCnt=1.
//  SET_BP 0x10, RUN from PC=0 -> 4 cpuEn cycles (PC 0,4,8,C), halts at cpuPc=0x10, bpHit=1;
//   RUN again -> PC 0x10 executes, bpHit=0, keeps running.
//  Regs x1..x31 preloaded i*3; DUMP with dumpReady toggling -> 32 beats, addr 0..31 in order,
//   data[0]=PC, data[i]=i*3, cmdReady=0 throughout, back to HALT.
//  STEP 100, HALT accepted on 3rd STEP cycle -> instrCnt=3; CLR_CNT on edge with cpuEn=1 -> instrCnt=0.
//  rst asserted during DUMP at dumpAddr=7 -> next cycle state=HALT, dumpValid=0, dumpAddr=0, instrCnt=0.

Source files
------------

// File: rtl/sr_debug_ctrl.sv
// Run-control sequencer for the single-cycle schoolRISCV core.
// Gates core advance (RUN / HALT / STEP n), stops on one PC breakpoint,
// counts retired instructions and streams PC + x1..x31 out over valid/ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmdValid/cmdReady/cmdOp/cmdArg host command channel
//   cpuPc, cpuEn                  core PC in, core advance enable out
//   dbgRegAddr, dbgRegData        core debug register port (addr 0 = PC)
//   dumpValid/dumpReady/dumpAddr/dumpData  register dump stream
//   state, bpHit, instrCnt        status
module sr_debug_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [2:0]        cmdOp,
  input  logic [31:0]       cmdArg,
  input  logic [31:0]       cpuPc,
  output logic              cpuEn,
  output logic [4:0]        dbgRegAddr,
  input  logic [31:0]       dbgRegData,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic [4:0]        dumpAddr,
  output logic [31:0]       dumpData,
  output logic [1:0]        state,
  output logic              bpHit,
  output logic [CNT_W-1:0]  instrCnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  // Command opcodes (0 is NOP and needs no decode)
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_DUMP    = 3'd6;
  localparam logic [2:0] OP_CLR_CNT = 3'd7;

  state_t              cur;
  logic                bp_en;
  logic [31:0]         bp_addr;
  logic                skip_bp;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_arg;
  logic                accept;
  logic                bp_match;

  assign state      = cur;
  assign cmdReady   = (cur != S_DUMP);
  assign accept     = cmdValid && cmdReady;
  assign dumpValid  = (cur == S_DUMP);
  assign dbgRegAddr = dumpValid ? dumpAddr : 5'd0;
  assign dumpData   = dbgRegData;

  // STEP 0 behaves as STEP 1
  assign step_arg = (cmdArg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmdArg[STEP_W-1:0];

  // Core enable; skip_bp lets a resumed RUN execute the instruction at bp_addr once
  always_comb begin
    bp_match = bp_en && (cpuPc == bp_addr) && !skip_bp;
    cpuEn    = 1'b0;
    case (cur)
      S_RUN:   cpuEn = !bp_match;
      S_STEP:  cpuEn = 1'b1;
      default: cpuEn = 1'b0;
    endcase
  end

  // Sequencer state, breakpoint registers, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_HALT;
      bp_en    <= 1'b0;
      bp_addr  <= '0;
      bpHit    <= 1'b0;
      instrCnt <= '0;
      step_cnt <= '0;
      dumpAddr <= '0;
      skip_bp  <= 1'b0;
    end else begin
      // CLR_CNT wins over a same-edge retirement
      if (accept && cmdOp == OP_CLR_CNT)
        instrCnt <= '0;
      else if (cpuEn)
        instrCnt <= instrCnt + CNT_W'(1);

      if (accept && cmdOp == OP_SET_BP) begin
        bp_en   <= 1'b1;
        bp_addr <= cmdArg;
      end else if (accept && cmdOp == OP_CLR_BP) begin
        bp_en <= 1'b0;
      end

      case (cur)
        S_HALT: begin
          if (accept) begin
            case (cmdOp)
              OP_RUN: begin
                cur     <= S_RUN;
                skip_bp <= 1'b1;
                bpHit   <= 1'b0;
              end
              OP_STEP: begin
                cur      <= S_STEP;
                step_cnt <= step_arg;
                bpHit    <= 1'b0;
              end
              OP_DUMP: begin
                cur      <= S_DUMP;
                dumpAddr <= '0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          skip_bp <= 1'b0;
          if (bp_match) begin
            cur   <= S_HALT;
            bpHit <= 1'b1;
          end else if (accept && cmdOp == OP_HALT) begin
            cur <= S_HALT;
          end
        end
        S_STEP: begin
          step_cnt <= step_cnt - STEP_W'(1);
          if (step_cnt == STEP_W'(1) || (accept && cmdOp == OP_HALT))
            cur <= S_HALT;
        end
        S_DUMP: begin
          if (dumpReady) begin
            if (dumpAddr == 5'd31) begin
              cur      <= S_HALT;
              dumpAddr <= '0;
            end else begin
              dumpAddr <= dumpAddr + 5'd1;
            end
          end
        end
        default: cur <= S_HALT;
      endcase
    end
  end

endmodule
